dep_mult_scheduler: RTL and testbench

DEP_MULT_SCHEDULER -- requirements
Module: dep_mult_scheduler

---
 rtl/dep_mult_scheduler_pkg.sv | 29 ++
 rtl/dom_lfsr16.sv | 39 +++
 rtl/dep_mult_scheduler.sv | 150 +++++++++++++++
 tb/tb_dep_mult_scheduler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dep_mult_scheduler_pkg.sv
// dep_mult_scheduler_pkg
//   Shared definitions for the DOM multiplier scheduler:
//   - state_e     : scheduler FSM states (warm-up, running)
//   - LFSR_TAPS   : feedback mask of the 16-bit randomness LFSR
//   - SHARE_W     : bits per share (GF(2^2) element)
//   - NSHARE      : shares per operand
//   - OP_W        : packed operand width {z, y, x}
//   - dbg_t       : debug view of the scheduler (FSM state and LFSR contents)
package dep_mult_scheduler_pkg;

  localparam int SHARE_W = 2;
  localparam int NSHARE  = 3;
  localparam int OP_W    = SHARE_W * NSHARE;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form:
  // feedback is the XOR of bits 0, 2, 3 and 5, shifted in at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    state_e      state;
    logic [15:0] lfsr;
  } dbg_t;

endpackage

// File: rtl/dom_lfsr16.sv
// dom_lfsr16
//   16-bit Fibonacci LFSR supplying fresh randomness to the multiplier.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset, loads seed
//     en   - advance one step this cycle
//     seed - reset value (must be nonzero)
//     q    - current LFSR state
module dom_lfsr16
  import dep_mult_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dep_mult_scheduler.sv
// dep_mult_scheduler
//   Shares one pipelined DOM multiplier (GF(2^2), 3 shares) between two
//   requesters. After reset the LFSR is warmed up for WARMUP cycles, then
//   requests are granted round-robin, one per cycle. Each grant is tagged
//   and its result is returned LAT cycles later on the requester's rsp pulse.
//   Ports:
//     clk, rst                 - clock, asynchronous active-high reset
//     reqN_valid/a/b/ready     - operand request channel of requester N
//     m_a, m_b, m_z            - operands and fresh randomness to the multiplier
//     m_aq, m_bq               - multiplier result shares
//     rspN_valid               - one-cycle result pulse to requester N
//     rsp_aq, rsp_bq           - result shares (zero when no pulse)
//     busy                     - an issued operation still awaits its response
//     dbg                      - FSM state and LFSR contents
//
// Handshake: an operand transfers in the cycle where reqN_valid and
// reqN_ready are both high. ready is a combinational function of both valids
// and the priority pointer; a requester keeps valid and operands stable until
// it sees ready. Responses have no ready: a requester must take the pulse.
module dep_mult_scheduler
  import dep_mult_scheduler_pkg::*;
#(
  parameter int          LAT    = 1,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          WARMUP = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [OP_W-1:0]    req0_a,
  input  logic [OP_W-1:0]    req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [OP_W-1:0]    req1_a,
  input  logic [OP_W-1:0]    req1_b,
  output logic               req1_ready,
  output logic [OP_W-1:0]    m_a,
  output logic [OP_W-1:0]    m_b,
  output logic [SHARE_W-1:0] m_z,
  input  logic [SHARE_W-1:0] m_aq,
  input  logic [SHARE_W-1:0] m_bq,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  output logic [SHARE_W-1:0] rsp_aq,
  output logic [SHARE_W-1:0] rsp_bq,
  output logic               busy,
  output dbg_t               dbg
);

  localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;

  state_e      state_q, state_d;
  logic [15:0] warm_cnt_q, warm_cnt_d;
  logic        ptr_q, ptr_d;
  logic [LAT-1:0] tag_valid_q, tag_valid_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic        gnt0;
  logic        gnt1;
  logic        lfsr_en;
  logic [15:0] lfsr_q;

  dom_lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (lfsr_en),
    .seed (SEED),
    .q    (lfsr_q)
  );

  // Next state, grants and multiplier operands. Operands are forced to zero
  // whenever nothing is granted so the shares never toggle without reason.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    ptr_d      = ptr_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    lfsr_en    = 1'b0;
    m_a        = '0;
    m_b        = '0;
    case (state_q)
      ST_INIT: begin
        lfsr_en    = 1'b1;
        warm_cnt_d = warm_cnt_q + 16'd1;
        if (warm_cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // ptr_q names the preferred side when both requesters are valid.
        gnt0 = req0_valid & (~ptr_q | ~req1_valid);
        gnt1 = req1_valid & ~gnt0;
        if (gnt0) begin
          m_a = req0_a;
          m_b = req0_b;
        end else if (gnt1) begin
          m_a = req1_a;
          m_b = req1_b;
        end
        // Each issued operation consumes one Z; the pointer moves to the
        // side that was not just served.
        if (gnt0 | gnt1) begin
          lfsr_en = 1'b1;
          ptr_d   = gnt0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Tag pipeline: stage k holds the grant issued k+1 cycles ago, so the last
  // stage lines up with the multiplier output LAT cycles after the grant.
  always_comb begin
    tag_valid_d    = '0;
    tag_id_d       = '0;
    tag_valid_d[0] = gnt0 | gnt1;
    tag_id_d[0]    = gnt1;
    for (int k = 1; k < LAT; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_id_d[k]    = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      warm_cnt_q  <= '0;
      ptr_q       <= 1'b0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      ptr_q       <= ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign m_z        = lfsr_q[SHARE_W-1:0];
  assign rsp0_valid = tag_valid_q[LAT-1] & ~tag_id_q[LAT-1];
  assign rsp1_valid = tag_valid_q[LAT-1] & tag_id_q[LAT-1];
  assign rsp_aq     = tag_valid_q[LAT-1] ? m_aq : '0;
  assign rsp_bq     = tag_valid_q[LAT-1] ? m_bq : '0;
  assign busy       = |tag_valid_q;
  assign dbg        = '{state: state_q, lfsr: lfsr_q};

endmodule

// File: tb/tb_dep_mult_scheduler.sv
// tb_dep_mult_scheduler
//   Three schedulers (LAT = 1, 3, 4) share clock and reset; each drives a
//   behavioural DOM multiplier. One scenario at a time exercises one of them
//   against a transaction-level model: warm-up count, round-robin choice,
//   LFSR sequence, and a queue of expected responses with due cycles.
module tb_dep_mult_scheduler;
  import dep_mult_scheduler_pkg::*;

  localparam int          WARMUP  = 16;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          LATS[3] = '{1, 3, 4};
  localparam int          EXP_W   = 35;  // {due cycle[31:0], id, product[1:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       v0[3], v1[3], r0[3], r1[3], p0[3], p1[3], bsy[3];
  logic [5:0] a0[3], b0[3], a1[3], b1[3], ma[3], mb[3];
  logic [1:0] mz[3], maq[3], mbq[3], raq[3], rbq[3];
  dbg_t       dbg_s[3];

  // ---------------- GF(2^2) reference arithmetic ----------------
  // Polynomial multiply modulo x^2 + x + 1.
  function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] acc;
    acc = '0;
    for (int i = 0; i < 2; i++) begin
      if (b[i]) acc = acc ^ (3'(a) << i);
    end
    if (acc[2]) acc = acc ^ 3'b111;
    return acc[1:0];
  endfunction

  function automatic logic [1:0] unshare(input logic [5:0] s);
    return s[5:4] ^ s[3:2] ^ s[1:0];
  endfunction

  // Behavioural multiplier: two output shares whose XOR is the product.
  function automatic logic [3:0] mult_shares(input logic [5:0] a, input logic [5:0] b,
                                             input logic [1:0] z);
    logic [1:0] aq;
    aq = z ^ gf_mul(a[1:0], b[1:0]);
    return {aq, gf_mul(unshare(a), unshare(b)) ^ aq};
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // ---------------- DUTs and multipliers ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = LATS[g];
    logic [3:0] pipe[4];

    dep_mult_scheduler #(.LAT(L), .SEED(SEED), .WARMUP(WARMUP)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v0[g]),
      .req0_a     (a0[g]),
      .req0_b     (b0[g]),
      .req0_ready (r0[g]),
      .req1_valid (v1[g]),
      .req1_a     (a1[g]),
      .req1_b     (b1[g]),
      .req1_ready (r1[g]),
      .m_a        (ma[g]),
      .m_b        (mb[g]),
      .m_z        (mz[g]),
      .m_aq       (maq[g]),
      .m_bq       (mbq[g]),
      .rsp0_valid (p0[g]),
      .rsp1_valid (p1[g]),
      .rsp_aq     (raq[g]),
      .rsp_bq     (rbq[g]),
      .busy       (bsy[g]),
      .dbg        (dbg_s[g])
    );

    always @(posedge clk) begin
      pipe[0] <= mult_shares(ma[g], mb[g], mz[g]);
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign maq[g] = pipe[L-1][3:2];
    assign mbq[g] = pipe[L-1][1:0];
  end

  // ---------------- reference model state / scoreboard ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  int          m_cyc;
  int          m_init_left;
  int          m_first_gnt;
  logic        m_ptr;
  logic [15:0] m_lfsr;
  logic [EXP_W-1:0] exp_q[$];
  int          gnt_log[$];
  int          rsp_log[$];
  logic [1:0]  last_rsp_prod;

  task automatic model_reset();
    m_cyc       = 1;
    m_init_left = WARMUP;
    m_first_gnt = -1;
    m_ptr       = 1'b0;
    m_lfsr      = SEED;
    exp_q.delete();
    gnt_log.delete();
    rsp_log.delete();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0;
      a0[i] = '0; b0[i] = '0; a1[i] = '0; b1[i] = '0;
    end
  endtask

  task automatic rand_ops(input int d);
    a0[d] = 6'($urandom); b0[d] = 6'($urandom);
    a1[d] = 6'($urandom); b1[d] = 6'($urandom);
  endtask

  // Reset pulse spanning one rising edge; inputs left as the caller set them.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of instance d: inputs were set by the caller at the falling
  // edge; outputs are scored against the model, then the model advances.
  task automatic step(input int d);
    logic             e_g0, e_g1, e_busy, pulse;
    logic [EXP_W-1:0] head;
    logic [5:0]       e_a, e_b;
    int               due;
    #1;
    e_busy = (exp_q.size() != 0);
    pulse  = 1'b0;
    head   = '0;
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      due  = int'(head[34:3]);
      pulse = (due == m_cyc);
    end
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (m_init_left == 0) begin
      if (v0[d] && v1[d]) begin
        e_g0 = ~m_ptr; e_g1 = m_ptr;
      end else begin
        e_g0 = v0[d]; e_g1 = v1[d];
      end
    end
    e_a = e_g0 ? a0[d] : (e_g1 ? a1[d] : 6'd0);
    e_b = e_g0 ? b0[d] : (e_g1 ? b1[d] : 6'd0);

    n_total++;
    if ({r0[d], r1[d]} !== {e_g0, e_g1}) begin
      n_bad++;
      $display("FAIL grant d%0d cyc%0d got=%b%b want=%b%b", d, m_cyc, r0[d], r1[d], e_g0, e_g1);
    end
    n_total++;
    if ({ma[d], mb[d]} !== {e_a, e_b}) begin
      n_bad++;
      $display("FAIL operands d%0d cyc%0d got=%h/%h want=%h/%h", d, m_cyc, ma[d], mb[d], e_a, e_b);
    end
    n_total++;
    if (mz[d] !== m_lfsr[1:0] || dbg_s[d].lfsr !== m_lfsr) begin
      n_bad++;
      $display("FAIL lfsr d%0d cyc%0d got=%h z=%h want=%h", d, m_cyc, dbg_s[d].lfsr, mz[d], m_lfsr);
    end
    n_total++;
    if (bsy[d] !== e_busy) begin
      n_bad++;
      $display("FAIL busy d%0d cyc%0d got=%b want=%b", d, m_cyc, bsy[d], e_busy);
    end
    n_total++;
    if ({p0[d], p1[d]} !== {pulse & ~head[2], pulse & head[2]}) begin
      n_bad++;
      $display("FAIL rsp_valid d%0d cyc%0d got=%b%b want=%b%b", d, m_cyc, p0[d], p1[d],
               pulse & ~head[2], pulse & head[2]);
    end
    n_total++;
    if (pulse) begin
      if ((raq[d] ^ rbq[d]) !== head[1:0]) begin
        n_bad++;
        $display("FAIL rsp_data d%0d cyc%0d got=%h want=%h", d, m_cyc, raq[d] ^ rbq[d], head[1:0]);
      end
      last_rsp_prod = raq[d] ^ rbq[d];
      rsp_log.push_back(int'(head[2]));
      void'(exp_q.pop_front());
    end else if ({raq[d], rbq[d]} !== 4'd0) begin
      n_bad++;
      $display("FAIL rsp_idle d%0d cyc%0d got=%h/%h want=0/0", d, m_cyc, raq[d], rbq[d]);
    end

    if (e_g0 || e_g1) begin
      exp_q.push_back({32'(m_cyc + LATS[d]), e_g1, gf_mul(unshare(e_a), unshare(e_b))});
      gnt_log.push_back(int'(e_g1));
      if (m_first_gnt < 0) m_first_gnt = m_cyc;
      m_ptr  = e_g0;
      m_lfsr = lfsr_next(m_lfsr);
    end else if (m_init_left > 0) begin
      m_init_left--;
      m_lfsr = lfsr_next(m_lfsr);
    end
    @(negedge clk);
    m_cyc++;
  endtask

  task automatic idle(input int d, input int n);
    v0[d] = 1'b0;
    v1[d] = 1'b0;
    for (int i = 0; i < n; i++) step(d);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    v0[0] = 1'b1; v1[0] = 1'b1;
    rand_ops(0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if ({r0[0], r1[0], p0[0], p1[0], bsy[0]} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b want=00000", {r0[0], r1[0], p0[0], p1[0], bsy[0]});
    end
    n_total++;
    if ({ma[0], mb[0], raq[0], rbq[0]} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_data got=%h want=0", {ma[0], mb[0], raq[0], rbq[0]});
    end
    n_total++;
    if (dbg_s[0].state !== ST_INIT || dbg_s[0].lfsr !== SEED) begin
      n_bad++;
      $display("FAIL reset_state got=%b/%h want=%b/%h", dbg_s[0].state, dbg_s[0].lfsr, ST_INIT, SEED);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < WARMUP + 1; i++) step(0);
    n_total++;
    if (m_first_gnt != WARMUP + 1 || gnt_log.size() != 1 || gnt_log[0] != 0) begin
      n_bad++;
      $display("FAIL first_grant got=cyc%0d n=%0d want=cyc%0d req0", m_first_gnt,
               gnt_log.size(), WARMUP + 1);
    end
    idle(0, 3);
  endtask

  task automatic test_alternate();
    int want[4];
    want = '{0, 1, 0, 1};
    do_reset();
    idle(0, WARMUP);
    gnt_log.delete();
    rsp_log.delete();
    v0[0] = 1'b1; v1[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_ops(0);
      step(0);
    end
    idle(0, 3);
    n_total++;
    if (gnt_log.size() != 4 || rsp_log.size() != 4) begin
      n_bad++;
      $display("FAIL alt_count got=%0d/%0d want=4/4", gnt_log.size(), rsp_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (gnt_log[i] != want[i] || rsp_log[i] != want[i]) begin
          n_bad++;
          $display("FAIL alt_order idx%0d got=%0d/%0d want=%0d", i, gnt_log[i], rsp_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_known_product();
    rsp_log.delete();
    last_rsp_prod = 2'd0;
    v0[0] = 1'b1;
    a0[0] = 6'b01_10_00;  // {Az,Ay,Ax} = {1,2,0}
    b0[0] = 6'b01_01_01;  // {Bz,By,Bx} = {1,1,1}
    step(0);
    idle(0, 3);
    n_total++;
    if (rsp_log.size() != 1 || last_rsp_prod !== 2'd3) begin
      n_bad++;
      $display("FAIL known_product got=n%0d/%0d want=n1/3", rsp_log.size(), last_rsp_prod);
    end
  endtask

  task automatic test_idle_z();
    for (int i = 0; i < 40; i++) begin
      v0[0] = ($urandom_range(0, 2) == 0);
      v1[0] = ($urandom_range(0, 2) == 0);
      rand_ops(0);
      step(0);
    end
    idle(0, 3);
  endtask

  task automatic test_reset_mid();
    do_reset();
    idle(1, WARMUP);
    v0[1] = 1'b1; v1[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops(1);
      step(1);
    end
    idle(1, 1);
    #1;
    n_total++;
    if (bsy[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_before_rst got=%b want=1", bsy[1]);
    end
    rst = 1'b1;
    #1;
    n_total++;
    if ({bsy[1], p0[1], p1[1], r0[1], r1[1], dbg_s[1].state} !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_rst_clear got=%b want=000000",
               {bsy[1], p0[1], p1[1], r0[1], r1[1], dbg_s[1].state});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(1, WARMUP + 8);
  endtask

  task automatic test_back_to_back();
    int want[3];
    want = '{1, 0, 1};
    do_reset();
    idle(2, WARMUP);
    gnt_log.delete();
    rsp_log.delete();
    for (int i = 0; i < 3; i++) begin
      v0[2] = (want[i] == 0);
      v1[2] = (want[i] == 1);
      rand_ops(2);
      step(2);
    end
    idle(2, 6);
    n_total++;
    if (gnt_log.size() != 3 || rsp_log.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d/%0d want=3/3", gnt_log.size(), rsp_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_total++;
        if (gnt_log[i] != want[i] || rsp_log[i] != want[i]) begin
          n_bad++;
          $display("FAIL b2b_order idx%0d got=%0d/%0d want=%0d", i, gnt_log[i], rsp_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      clear_inputs();
      do_reset();
      for (int i = 0; i < WARMUP + 60; i++) begin
        v0[d] = ($urandom_range(0, 1) == 1);
        v1[d] = ($urandom_range(0, 1) == 1);
        rand_ops(d);
        step(d);
      end
      idle(d, 6);
      n_total++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL random_drain d%0d got=%0d pending want=0", d, exp_q.size());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alternate();
    test_known_product();
    test_idle_z();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
